// File: rtl/qq_pkg.sv
// Shared types and constants for the qq phase sequencer: FSM state enum,
// default parameter values and the configuration address-width helper.
package qq_pkg;

    typedef enum logic {
        QQ_IDLE = 1'b0,
        QQ_RUN  = 1'b1
    } qq_state_e;

    localparam int QQ_CNT_W  = 5;
    localparam int QQ_PARA_W = 6;
    localparam int QQ_SLOTS  = 3;

    // Addresses 0..slots-1 select a slot register, address slots the terminal count.
    function automatic int qq_addr_w(input int slots);
        return (slots < 1) ? 1 : $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/qq_slot_prio_enc.sv
// Combinational priority encoder: SLOTS-bit match vector to a one-hot
// vector holding only the highest-index set bit (all-zero if none set).
module qq_slot_prio_enc #(
    parameter int SLOTS = 3
) (
    input  logic [SLOTS-1:0] match,
    output logic [SLOTS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (match[k]) begin
                onehot    = '0;
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qq_phase_sequencer.sv
// Echo-indexed phase sequencer with shadow/active config banks and a run FSM.
// Optional sticky per-slot hit flags are built when QQ_SEQ_STICKY_EN is defined.
module qq_phase_sequencer
    import qq_pkg::*;
#(
    parameter int CNT_W  = QQ_CNT_W,
    parameter int PARA_W = QQ_PARA_W,
    parameter int SLOTS  = QQ_SLOTS
) (
    input  logic                         clk_sys,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [qq_addr_w(SLOTS)-1:0]  wr_addr,
    input  logic [PARA_W-1:0]            wr_data,
    input  logic                         seq_start,
    input  logic                         abort,
    input  logic                         echo_tick,
    input  logic                         state_start,
    output logic [SLOTS:0]               i,
    output logic [CNT_W-1:0]             count_o,
    output logic                         busy,
    output logic                         done,
    output qq_state_e                    state_dbg
`ifdef QQ_SEQ_STICKY_EN
    ,
    output logic [SLOTS-1:0]             hit_flags
`endif
);

    localparam int ADDR_W = qq_addr_w(SLOTS);
    localparam logic [ADDR_W-1:0] TERM_ADDR = ADDR_W'(SLOTS);

    // Control pulses: seq_start is accepted only in IDLE with abort low;
    // abort in RUN wins over a same-cycle terminal echo_tick; done is a
    // one-cycle pulse in the cycle busy falls after a normal completion.
    qq_state_e         state;
    logic [CNT_W-1:0]  count;
    logic              done_q;
    logic [SLOTS:0]    i_q;

    logic [PARA_W-1:0] shadow_slot [SLOTS];
    logic [CNT_W-1:0]  shadow_term;
    logic [PARA_W-1:0] active_slot [SLOTS];
    logic [CNT_W-1:0]  active_term;

    logic [PARA_W-1:0] count_ext;
    logic [SLOTS-1:0]  match;
    logic [SLOTS-1:0]  win;
    logic [SLOTS-1:0]  code;

    assign count_ext = PARA_W'(count);

    always_comb begin
        match = '0;
        for (int k = 0; k < SLOTS; k++) begin
            match[k] = (count_ext == active_slot[k]);
        end
    end

    qq_slot_prio_enc #(
        .SLOTS (SLOTS)
    ) u_prio_enc (
        .match  (match),
        .onehot (win)
    );

    assign code = (state == QQ_RUN) ? win : '0;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SLOTS; k++) begin
                shadow_slot[k] <= '0;
            end
            shadow_term <= '0;
        end else if (wr_en) begin
            if (wr_addr < TERM_ADDR) begin
                shadow_slot[wr_addr] <= wr_data;
            end else if (wr_addr == TERM_ADDR) begin
                shadow_term <= wr_data[CNT_W-1:0];
            end
        end
    end

`ifdef QQ_SEQ_STICKY_EN
    logic [SLOTS-1:0] hit_q;
    assign hit_flags = hit_q;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state  <= QQ_IDLE;
            count  <= '0;
            done_q <= 1'b0;
            i_q    <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                active_slot[k] <= '0;
            end
            active_term <= '0;
`ifdef QQ_SEQ_STICKY_EN
            hit_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            i_q    <= {code, state_start};
`ifdef QQ_SEQ_STICKY_EN
            if (state == QQ_RUN) begin
                hit_q <= hit_q | code;
            end
`endif
            case (state)
                QQ_IDLE: begin
                    if (seq_start && !abort) begin
                        state       <= QQ_RUN;
                        count       <= '0;
                        active_slot <= shadow_slot;
                        active_term <= shadow_term;
`ifdef QQ_SEQ_STICKY_EN
                        hit_q <= '0;
`endif
                    end
                end
                QQ_RUN: begin
                    if (abort) begin
                        state <= QQ_IDLE;
                    end else if (echo_tick) begin
                        if (count == active_term) begin
                            state  <= QQ_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= QQ_IDLE;
            endcase
        end
    end

    assign i         = i_q;
    assign count_o   = count;
    assign busy      = (state == QQ_RUN);
    assign done      = done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_qq_phase_sequencer.sv
// Randomized bench for qq_phase_sequencer against a cycle-level behavioural model;
// covers the directed scenarios plus a random start/abort/tick/write phase.
module tb_qq_phase_sequencer;
    import qq_pkg::*;

    localparam int CNT_W  = 5;
    localparam int PARA_W = 6;
    localparam int SLOTS  = 3;
    localparam int ADDR_W = 2;
    localparam int TERM_MAX = (1 << CNT_W) - 1;

    logic              clk_sys = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [PARA_W-1:0] wr_data = '0;
    logic              seq_start = 1'b0;
    logic              abort = 1'b0;
    logic              echo_tick = 1'b0;
    logic              state_start = 1'b0;
    logic [SLOTS:0]    i;
    logic [CNT_W-1:0]  count_o;
    logic              busy;
    logic              done;
    qq_state_e         state_dbg;
    logic [SLOTS-1:0]  hit_flags;

    int n_checks = 0;
    int n_errors = 0;

    logic [SLOTS:0] exp_q[$];

    // Behavioural model of the sequencer
    int m_sh [SLOTS];
    int m_act [SLOTS];
    int m_sh_term, m_act_term, m_cnt, m_hit;
    bit m_run, m_done;

    qq_phase_sequencer #(
        .CNT_W  (CNT_W),
        .PARA_W (PARA_W),
        .SLOTS  (SLOTS)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .seq_start   (seq_start),
        .abort       (abort),
        .echo_tick   (echo_tick),
        .state_start (state_start),
        .i           (i),
        .count_o     (count_o),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
`ifdef QQ_SEQ_STICKY_EN
        ,
        .hit_flags   (hit_flags)
`endif
    );

`ifndef QQ_SEQ_STICKY_EN
    assign hit_flags = '0;
`endif

    // Clock and watchdog
    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SLOTS; k++) begin
            m_sh[k]  = 0;
            m_act[k] = 0;
        end
        m_sh_term = 0; m_act_term = 0; m_cnt = 0; m_hit = 0;
        m_run = 1'b0; m_done = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        logic [SLOTS:0] exp_i;
        exp_i = exp_q.pop_front();
        check("i", i, exp_i);
        check("count", count_o, m_cnt);
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("state", state_dbg, m_run);
`ifdef QQ_SEQ_STICKY_EN
        check("hit", hit_flags, m_hit);
`endif
    endtask

    // One clock cycle: predict from current inputs, advance, compare
    task automatic tick();
        int win;
        int exp_i;
        state_start = 1'($urandom_range(0, 1));
        win = -1;
        if (m_run) begin
            for (int k = SLOTS - 1; k >= 0; k--) begin
                if (win < 0 && m_act[k] == m_cnt) win = k;
            end
        end
        exp_i = (win >= 0) ? (1 << (win + 1)) : 0;
        if (state_start) exp_i = exp_i | 1;
        exp_q.push_back(exp_i[SLOTS:0]);
        if (win >= 0) m_hit = m_hit | (1 << win);
        m_done = 1'b0;
        if (!m_run) begin
            if (seq_start && !abort) begin
                m_run = 1'b1;
                m_cnt = 0;
                m_act = m_sh;
                m_act_term = m_sh_term;
                m_hit = 0;
            end
        end else if (abort) begin
            m_run = 1'b0;
        end else if (echo_tick) begin
            if (m_cnt == m_act_term) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        if (wr_en) begin
            if (int'(wr_addr) < SLOTS) m_sh[wr_addr] = int'(wr_data);
            else if (int'(wr_addr) == SLOTS) m_sh_term = int'(wr_data) % (TERM_MAX + 1);
        end
        @(posedge clk_sys);
        #1;
        check_outputs();
        wr_en = 1'b0; seq_start = 1'b0; abort = 1'b0; echo_tick = 1'b0;
    endtask

    // Driver tasks
    task automatic wr(input int addr, input int data);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = PARA_W'(data);
        tick();
    endtask

    task automatic config3(input int s0, input int s1, input int s2, input int term);
        wr(0, s0); wr(1, s1); wr(2, s2); wr(SLOTS, term);
    endtask

    task automatic start();
        seq_start = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic echo(input int n);
        repeat (n) begin
            echo_tick = 1'b1;
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic echo_to(input int target);
        int guard = 0;
        while (m_run && m_cnt != target && guard < 64) begin
            echo_tick = 1'b1;
            tick();
            guard++;
        end
        check("echo_to_reached", m_cnt, target);
    endtask

    initial begin
        int r;
        model_reset();
        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_i", i, 0);
        check("rst_count", count_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit_flags, 0);
        rst_n = 1'b1;
        idle(2);

        // Defaults: slots {2,5,9}, terminal 10, 11 echo ticks
        config3(2, 5, 9, 10);
        start();
        echo(11);
        check("defaults_done_seen", busy, 0);
        idle(3);

        // Overlapping slots all at 4
        config3(4, 4, 4, 6);
        start();
        echo_to(4);
        tick();
        check("overlap_code", i[SLOTS:1], 3'b100);
        echo(4);
        idle(2);

        // Shadow update during RUN
        config3(2, 5, 9, 10);
        start();
        echo(1);
        wr(0, 7);
        echo(10);
        idle(1);
        start();
        echo(11);
        idle(2);

        // Abort at count 6
        config3(2, 5, 9, 10);
        start();
        echo_to(6);
        abort = 1'b1;
        tick();
        check("abort_count_hold", count_o, 6);
        idle(3);
        check("abort_code_clear", i[SLOTS:1], 0);

        // Simultaneous start + abort in IDLE, then a lone start
        seq_start = 1'b1; abort = 1'b1;
        tick();
        check("start_abort_idle", busy, 0);
        idle(1);
        start();
        echo(11);
        idle(2);

        // Terminal at the counter maximum
        config3(31, 40, 0, TERM_MAX);
        start();
        repeat (TERM_MAX + 1) begin
            echo_tick = 1'b1;
            tick();
        end
        idle(2);

        // Random phase
        for (int n = 0; n < 700; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                wr_en = 1'b1;
                wr_addr = ADDR_W'($urandom_range(0, SLOTS));
                wr_data = PARA_W'($urandom_range(0, (1 << PARA_W) - 1));
                if (wr_addr == ADDR_W'(SLOTS)) wr_data = PARA_W'($urandom_range(0, 14));
            end
            if (r >= 5 && r < 15) seq_start = 1'b1;
            if (r >= 15 && r < 18) abort = 1'b1;
            if (r >= 18 && r < 20) begin seq_start = 1'b1; abort = 1'b1; end
            if (r >= 20 && r < 70) echo_tick = 1'b1;
            tick();
        end
        idle(2);

        // Asynchronous reset mid-run at count 3
        config3(2, 5, 9, 10);
        start();
        echo_to(3);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_i", i, 0);
        check("arst_count", count_o, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hit", hit_flags, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            echo_tick = 1'b1;
            tick();
        end
        config3(2, 5, 9, 10);
        start();
        echo(11);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
